// File: rtl/alu_md_sequencer.sv
// ALU control decoder with an iterative unsigned multiply/divide sequencer.
// Optional macro ALU_MD_SEQUENCER_DIV0_TRAP_EN: divide-by-zero completes early with div0_err.
module alu_md_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   aluop,
  input  logic [5:0]   funct,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [3:0]   aluctrl,
  output logic         use_alu,
  output logic [W-1:0] md_result,
  output logic         result_valid,
  output logic         busy,
  output logic         div0_err,
  output logic [1:0]   state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and the requester holds its inputs until then.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(W);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic [W:0]    acc;

  logic [3:0]    dec_code;
  logic          accept;
  logic          is_mul;
  logic          is_div;
  logic          trap;
  logic          last_iter;

  logic [W-1:0]  mul_nx;
  logic [W:0]    rem_sh;
  logic [W+1:0]  diff;
  logic [W:0]    rem_nx;
  logic [W-1:0]  quo_nx;

  always_comb begin
    dec_code = 4'hF;
    case (aluop)
      2'b00: dec_code = 4'd2;
      2'b01: dec_code = 4'd10;
      2'b11: dec_code = 4'd1;
      default: begin
        case (funct)
          6'h20:   dec_code = 4'd2;
          6'h22:   dec_code = 4'd10;
          6'h24:   dec_code = 4'd0;
          6'h25:   dec_code = 4'd1;
          6'h2A:   dec_code = 4'd11;
          6'h18:   dec_code = 4'd4;
          6'h1A:   dec_code = 4'd5;
          default: dec_code = 4'hF;
        endcase
      end
    endcase
  end

  assign req_ready    = (state == S_IDLE);
  assign accept       = req_valid && req_ready;
  assign is_mul       = (dec_code == 4'd4);
  assign is_div       = (dec_code == 4'd5);
  assign result_valid = (state == S_DONE);
  assign busy         = (state == S_MUL) || (state == S_DIV);
  assign last_iter    = (cnt == CW'(W - 1));
  assign state_dbg    = state;

  // Shift-add step: x is the shifted multiplicand, y the remaining multiplier bits.
  assign mul_nx = y[0] ? (acc[W-1:0] + x) : acc[W-1:0];

  // Restoring step: x shifts the dividend out and quotient bits in, y is the divisor.
  assign rem_sh = {acc[W-1:0], x[W-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, y};
  assign rem_nx = diff[W+1] ? rem_sh : diff[W:0];
  assign quo_nx = {x[W-2:0], ~diff[W+1]};

`ifdef ALU_MD_SEQUENCER_DIV0_TRAP_EN
  assign trap = is_div && (b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div0_err <= 1'b0;
    end else begin
      div0_err <= accept && trap;
    end
  end
`else
  assign trap     = 1'b0;
  assign div0_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      aluctrl   <= 4'd0;
      use_alu   <= 1'b1;
      md_result <= '0;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      acc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            aluctrl <= dec_code;
            use_alu <= !(is_mul || is_div);
            cnt     <= '0;
            acc     <= '0;
            x       <= a;
            y       <= b;
            if (trap) begin
              md_result <= '0;
              state     <= S_DONE;
            end else if (is_mul) begin
              state <= S_MUL;
            end else if (is_div) begin
              state <= S_DIV;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc <= {1'b0, mul_nx};
          x   <= x << 1;
          y   <= y >> 1;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            md_result <= mul_nx;
            state     <= S_DONE;
          end
        end
        S_DIV: begin
          acc <= rem_nx;
          x   <= quo_nx;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            md_result <= quo_nx;
            state     <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_sequencer.sv
// Directed plus randomized bench for alu_md_sequencer with an arithmetic reference model.
module tb_alu_md_sequencer;

  localparam int W = 32;
`ifdef ALU_MD_SEQUENCER_DIV0_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   aluop = 2'b00;
  logic [5:0]   funct = 6'h00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   aluctrl;
  logic         use_alu;
  logic [W-1:0] md_result;
  logic         result_valid;
  logic         busy;
  logic         div0_err;
  logic [1:0]   state_dbg;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [W-1:0] model_md = '0;

  alu_md_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .aluctrl(aluctrl),
    .use_alu(use_alu), .md_result(md_result), .result_valid(result_valid),
    .busy(busy), .div0_err(div0_err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] model_code(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'd2;
    if (op == 2'b01) return 4'd10;
    if (op == 2'b11) return 4'd1;
    case (fn)
      6'h20: return 4'd2;
      6'h22: return 4'd10;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h2A: return 4'd11;
      6'h18: return 4'd4;
      6'h1A: return 4'd5;
      default: return 4'hF;
    endcase
  endfunction

  // One request from presentation to the cycle after its completion pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input bit toggle, input bit hold);
    logic [3:0] code;
    bit md, dz;
    int exp_lat, lat, busy_n, extra;
    logic [63:0] prod;
    code = model_code(op, fn);
    md = (code == 4'd4) || (code == 4'd5);
    dz = (code == 4'd5) && (ib == '0);
    if (code == 4'd4) begin
      prod = 64'(ia) * 64'(ib);
      model_md = prod[W-1:0];
    end else if (code == 4'd5) begin
      model_md = dz ? (TRAP ? '0 : '1) : ia / ib;
    end
    exp_lat = (md && !(dz && TRAP)) ? W + 1 : 1;

    @(negedge clk);
    req_valid = 1'b1; aluop = op; funct = fn; a = ia; b = ib;
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    lat = 1; busy_n = 0; extra = 0;
    while (!result_valid && lat < W + 8) begin
      if (busy) busy_n++;
      if (hold && req_ready) extra++;
      if (toggle) begin a = $urandom; b = $urandom; end
      @(posedge clk); #1;
      lat++;
    end
    if (hold && req_ready) extra++;
    req_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_aluctrl"}, 64'(aluctrl), 64'(code));
    check({tag, "_use_alu"}, 64'(use_alu), 64'(!md));
    check({tag, "_md_result"}, 64'(md_result), 64'(model_md));
    check({tag, "_div0_err"}, 64'(div0_err), 64'(dz && TRAP));
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
    if (hold) check({tag, "_extra_accepts"}, 64'(extra), 64'd0);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 64'(result_valid), 64'd0);
    check({tag, "_ready_again"}, 64'(req_ready), 64'd1);
    check({tag, "_div0_end"}, 64'(div0_err), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_aluctrl"}, 64'(aluctrl), 64'd0);
    check({tag, "_use_alu"}, 64'(use_alu), 64'd1);
    check({tag, "_md_result"}, 64'(md_result), 64'd0);
    check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_div0_err"}, 64'(div0_err), 64'd0);
  endtask

  initial begin
    logic [5:0] fn_tab [8];
    logic [1:0] op;
    logic [5:0] fn;
    logic [W-1:0] ra, rb;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h1A, 6'h3F};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("slt", 2'b10, 6'h2A, 32'h0, 32'h0, 1'b0, 1'b0);
    run_op("mul_vec", 2'b10, 6'h18, 32'h0001_0003, 32'h0001_0002, 1'b0, 1'b0);
    run_op("div_vec", 2'b10, 6'h1A, 32'd100, 32'd7, 1'b1, 1'b0);
    run_op("div_zero", 2'b10, 6'h1A, 32'd1234, 32'd0, 1'b0, 1'b0);
    run_op("bad_funct", 2'b10, 6'h3F, 32'h5, 32'h6, 1'b0, 1'b0);
    run_op("held_mul", 2'b10, 6'h18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_op("held_add", 2'b00, 6'h00, 32'h1, 32'h2, 1'b0, 1'b1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    req_valid = 1'b1; aluop = 2'b10; funct = 6'h18; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mid_mul_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_md = '0;
    repeat (2) begin
      @(posedge clk); #1;
      check("mid_rst_no_valid", 64'(result_valid), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1; aluop = 2'b00; funct = 6'h00;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("post_rst_valid", 64'(result_valid), 64'd1);
    check("post_rst_aluctrl", 64'(aluctrl), 64'd2);
    check("post_rst_md", 64'(md_result), 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = fn_tab[$urandom_range(0, 7)];
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom >> $urandom_range(0, 28);
      run_op($sformatf("rand%0d", i), op, fn, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
